// File: rtl/counter_4bit.sv
// Dual 4-bit free-running counter: up-count from 0, down-count from F.
// Both advance every rising edge; cnt_one tracks ~cnt_zero.
module counter_4bit (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] cnt_zero,
  output logic [3:0] cnt_one
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_zero <= 4'h0;
      cnt_one  <= 4'hF;
    end else begin
      cnt_zero <= cnt_zero + 4'd1;
      cnt_one  <= cnt_one - 4'd1;
    end
  end

endmodule

// File: tb/tb_counter_4bit.sv
// Directed bench for counter_4bit.
// Reference count is a plain edge counter kept in the bench.
`timescale 1ns/100ps
module tb_counter_4bit;

  logic       clk;
  logic       reset;
  logic [3:0] cnt_zero;
  logic [3:0] cnt_one;

  int tests;
  int fails;
  int n;

  counter_4bit dut (
    .clk      (clk),
    .reset    (reset),
    .cnt_zero (cnt_zero),
    .cnt_one  (cnt_one)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string      tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [3:0] e;
    e = n[3:0];
    chk({tag, "_up"}, cnt_zero, e);
    chk({tag, "_dn"}, cnt_one, 4'hF - e);
    chk({tag, "_inv"}, cnt_zero ^ cnt_one, 4'hF);
  endtask

  // k rising edges, checking 1ns after each
  task automatic tick(input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      if (reset) n = n + 1;
      chk_state(tag);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    n     = 0;
    reset = 1'b1;

    // power-on reset pulse before the first edge
    #1 reset = 1'b0;
    #0.5;
    chk("por_up", cnt_zero, 4'h0);
    chk("por_dn", cnt_one, 4'hF);
    #0.5 reset = 1'b1;
    #1;
    chk("rel_up", cnt_zero, 4'h0);
    chk("rel_dn", cnt_one, 4'hF);
    tick(1, "first");
    chk("first_up", cnt_zero, 4'h1);
    chk("first_dn", cnt_one, 4'hE);

    // free run to 20 edges since release
    tick(19, "run");
    chk("run20_up", cnt_zero, 4'h4);
    chk("run20_dn", cnt_one, 4'hB);

    // wrap-around from a fresh reset
    @(negedge clk);
    #2 reset = 1'b0;
    n = 0;
    #1;
    chk_state("rst2");
    #1 reset = 1'b1;
    tick(15, "pre_wrap");
    chk("w15_up", cnt_zero, 4'hF);
    chk("w15_dn", cnt_one, 4'h0);
    tick(1, "wrap");
    chk("w16_up", cnt_zero, 4'h0);
    chk("w16_dn", cnt_one, 4'hF);

    // asynchronous reset mid-count at 9
    tick(9, "to9");
    chk("at9_up", cnt_zero, 4'h9);
    @(negedge clk);
    #2 reset = 1'b0;
    n = 0;
    #0.5;
    chk("async_up", cnt_zero, 4'h0);
    chk("async_dn", cnt_one, 4'hF);

    // reset held across 5 edges
    tick(5, "held");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_state("held_rel");
    tick(1, "after_held");
    chk("ah_up", cnt_zero, 4'h1);
    chk("ah_dn", cnt_one, 4'hE);

    tick(3, "tail");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
